// File: rtl/switch_debouncer_if.sv
// Switch bus between the raw board switches and the debouncer: raw levels in, clean
// levels and edge pulses out.
interface switch_debouncer_if #(
  parameter int unsigned NUM_SW = 18
);
  logic [NUM_SW-1:0] SWITCH_I;
  logic [NUM_SW-1:0] SWITCH_DB_O;
  logic [NUM_SW-1:0] SWITCH_RISE_O;
  logic [NUM_SW-1:0] SWITCH_FALL_O;
  logic              SWITCH_CHANGE_O;

  modport master (
    output SWITCH_I,
    input  SWITCH_DB_O,
    input  SWITCH_RISE_O,
    input  SWITCH_FALL_O,
    input  SWITCH_CHANGE_O
  );

  modport slave (
    input  SWITCH_I,
    output SWITCH_DB_O,
    output SWITCH_RISE_O,
    output SWITCH_FALL_O,
    output SWITCH_CHANGE_O
  );
endinterface

// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: 2-flop synchronizer, shared sample-tick prescaler and a
// per-bit stability counter, plus one-cycle rise/fall pulses on the clean levels.
module switch_debouncer #(
  parameter int unsigned NUM_SW       = 18,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned STABLE_TICKS = 10
) (
  input logic               CLOCK_50_I,
  input logic               RESET_I,
  switch_debouncer_if.slave sw_if
);
  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam int unsigned CntW = $clog2(STABLE_TICKS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

  logic [NUM_SW-1:0] sync1_q, sync2_q;
  logic [NUM_SW-1:0] db_q, db_d;
  logic [NUM_SW-1:0] db_dly_q;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   cnt_q [NUM_SW];
  logic [CntW-1:0]   cnt_d [NUM_SW];
  logic              tick;

  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? '0 : div_q + 1'b1;
    db_d  = db_q;
    for (int i = 0; i < int'(NUM_SW); i++) begin
      cnt_d[i] = cnt_q[i];
      // Any sample agreeing with the accepted level restarts that bit's window.
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CntLast) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      div_q    <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < int'(NUM_SW); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sw_if.SWITCH_I;
      sync2_q  <= sync1_q;
      div_q    <= div_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
      for (int i = 0; i < int'(NUM_SW); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pulses are masked while reset is held so no stale edge escapes around reset.
  always_comb begin
    sw_if.SWITCH_DB_O     = db_q;
    sw_if.SWITCH_RISE_O   = RESET_I ? '0 : (db_q & ~db_dly_q);
    sw_if.SWITCH_FALL_O   = RESET_I ? '0 : (~db_q & db_dly_q);
    sw_if.SWITCH_CHANGE_O = |(sw_if.SWITCH_RISE_O | sw_if.SWITCH_FALL_O);
  end
endmodule
